// File: rtl/ps2_interface.sv
// Receive-only PS/2 keyboard port: synchronizes and glitch-filters the PS/2 lines,
// deframes 11-bit frames and strobes each received byte out with error reporting.
module ps2_interface #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       reset,
    inout  wire        ps2_clk,
    inout  wire        ps2_data,
    output logic [7:0] rx_data,
    output logic       read_data,
    output logic       busy,
    output logic       err
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_RECEIVE, S_DONE} state_t;

    // The lines are open-collector inputs only; this block never pulls them low.
    assign ps2_clk  = 1'bz;
    assign ps2_data = 1'bz;

    logic          clk_meta_q, clk_sync_q, dat_meta_q, dat_sync_q;
    logic          filt_q, filt_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    state_t        state_q, state_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [9:0]    shift_q, shift_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          read_data_q, read_data_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;
    logic          fall_s;
    logic [9:0]    frame_s;
    logic          frame_ok_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            dat_meta_q  <= 1'b1;
            dat_sync_q  <= 1'b1;
            filt_q      <= 1'b1;
            filt_cnt_q  <= '0;
            state_q     <= S_IDLE;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 10'd0;
            to_cnt_q    <= '0;
            rx_data_q   <= 8'h00;
            read_data_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            clk_meta_q  <= ps2_clk;
            clk_sync_q  <= clk_meta_q;
            dat_meta_q  <= ps2_data;
            dat_sync_q  <= dat_meta_q;
            filt_q      <= filt_d;
            filt_cnt_q  <= filt_cnt_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            to_cnt_q    <= to_cnt_d;
            rx_data_q   <= rx_data_d;
            read_data_q <= read_data_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        filt_d      = filt_q;
        filt_cnt_d  = filt_cnt_q;
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        to_cnt_d    = to_cnt_q;
        rx_data_d   = rx_data_q;
        read_data_d = 1'b0;
        busy_d      = busy_q;
        err_d       = 1'b0;

        // Filtered clock flips only after FILTER_LEN consecutive disagreeing samples.
        if (clk_sync_q == filt_q) begin
            filt_cnt_d = '0;
        end else if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
            filt_d     = clk_sync_q;
            filt_cnt_d = '0;
        end else begin
            filt_cnt_d = filt_cnt_q + FW'(1);
        end
        fall_s = filt_q & ~filt_d;

        // Bits arrive LSB-first, so the newest bit enters at the top.
        frame_s    = {dat_sync_q, shift_q[9:1]};
        frame_ok_s = (^frame_s[8:0]) & frame_s[9];

        case (state_q)
            S_IDLE: begin
                to_cnt_d = '0;
                if (fall_s && !dat_sync_q) begin
                    state_d   = S_RECEIVE;
                    bit_cnt_d = 4'd0;
                    busy_d    = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RECEIVE: begin
                if (fall_s) begin
                    to_cnt_d = '0;
                    shift_d  = frame_s;
                    if (bit_cnt_q == 4'd9) begin
                        state_d     = S_DONE;
                        busy_d      = 1'b0;
                        read_data_d = 1'b1;
                        if (frame_ok_s) begin
                            rx_data_d = frame_s[7:0];
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d  = S_IDLE;
                    busy_d   = 1'b0;
                    err_d    = 1'b1;
                    to_cnt_d = '0;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
            end
            S_DONE: begin
                state_d  = S_IDLE;
                to_cnt_d = '0;
            end
            default: begin
                state_d  = S_IDLE;
                busy_d   = 1'b0;
                to_cnt_d = '0;
            end
        endcase
    end

    assign rx_data   = rx_data_q;
    assign read_data = read_data_q;
    assign busy      = busy_q;
    assign err       = err_q;
endmodule

// File: tb/tb_ps2_interface.sv
// Scoreboard bench for ps2_interface: stimulus pushes expected strobes into a queue,
// a negedge monitor pops and compares whenever the DUT strobes.
module tb_ps2_interface;
    localparam int FL   = 8;
    localparam int TO   = 1500;
    localparam int HALF = 30;

    typedef struct packed {
        logic       rd;
        logic       er;
        logic [7:0] rx;
    } exp_t;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       drv_clk = 1'b1;
    logic       drv_dat = 1'b1;
    wire        ps2_clk_w;
    wire        ps2_data_w;
    logic [7:0] rx_data;
    logic       read_data, busy, err;
    logic       prev_rd = 1'b0;
    logic [7:0] last_valid = 8'h00;
    exp_t       exp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    assign ps2_clk_w  = drv_clk;
    assign ps2_data_w = drv_dat;

    ps2_interface #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk_w),
        .ps2_data  (ps2_data_w),
        .rx_data   (rx_data),
        .read_data (read_data),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
    endtask

    // Drives the first nbits of a frame (bit 0 = start), device-style: data changes while clock high.
    task automatic send_bits(input logic [10:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk) drv_dat = bits[i];
            cyc(HALF);
            @(negedge clk) drv_clk = 1'b0;
            cyc(HALF);
            @(negedge clk) drv_clk = 1'b1;
            if (i == 3) begin
                @(negedge clk);
                check("busy_mid_frame", 32'(busy), 32'd1);
            end
        end
        cyc(HALF);
    endtask

    // kind: 0 good, 1 parity flipped, 2 stop bit low.
    task automatic frame(input logic [7:0] b, input int kind);
        logic par, stop, valid;
        par  = ($countones(b) % 2 == 0);
        stop = 1'b1;
        if (kind == 1) par = ~par;
        if (kind == 2) stop = 1'b0;
        valid = (($countones(b) + int'(par)) % 2 == 1) && stop;
        if (valid) last_valid = b;
        exp_q.push_back('{rd: 1'b1, er: !valid, rx: last_valid});
        send_bits({stop, par, b, 1'b0}, 11);
    endtask

    always @(negedge clk) begin
        if (!reset && (read_data || err)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", {22'd0, read_data, err, rx_data}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("read_data", 32'(read_data), 32'(e.rd));
                check("err", 32'(err), 32'(e.er));
                check("rx_data", 32'(rx_data), 32'(e.rx));
                check("busy_at_strobe", 32'(busy), 32'd0);
                if (read_data) check("read_data_width", 32'(prev_rd), 32'd0);
            end
        end
        prev_rd <= read_data;
    end

    initial begin
        logic [7:0] b;
        int         k;
        cyc(5);
        @(negedge clk);
        check("reset_rx_data", 32'(rx_data), 32'h00);
        check("reset_read_data", 32'(read_data), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        reset = 1'b0;
        cyc(20);

        frame(8'h1C, 0);
        frame(8'hF0, 0);
        frame(8'h1C, 0);
        frame(8'h1C, 1);
        frame(8'h1C, 2);

        // Short low glitch on the clock line with data low must be filtered out.
        @(negedge clk) drv_dat = 1'b0;
        drv_clk = 1'b0;
        cyc(3);
        @(negedge clk) drv_clk = 1'b1;
        cyc(40);
        @(negedge clk);
        check("busy_after_glitch", 32'(busy), 32'd0);
        drv_dat = 1'b1;
        cyc(20);

        // Start plus three data bits, then silence until the frame times out.
        exp_q.push_back('{rd: 1'b0, er: 1'b1, rx: last_valid});
        send_bits({7'h7F, 4'($urandom_range(0, 7)) << 1}, 4);
        @(negedge clk) drv_dat = 1'b1;
        cyc(TO + 100);
        @(negedge clk);
        check("busy_after_timeout", 32'(busy), 32'd0);
        frame(8'h1C, 0);

        // Reset in the middle of a frame discards it.
        send_bits({2'b11, 8'h29, 1'b0}, 6);
        @(negedge clk) reset = 1'b1;
        cyc(3);
        @(negedge clk) reset = 1'b0;
        last_valid = 8'h00;
        check("rx_data_after_reset", 32'(rx_data), 32'h00);
        check("busy_after_reset", 32'(busy), 32'd0);
        cyc(20);
        frame(8'h29, 0);

        for (int i = 0; i < 20; i++) begin
            b = 8'($urandom_range(0, 255));
            k = $urandom_range(0, 3);
            frame(b, (k == 3) ? 0 : k);
        end

        cyc(200);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
